// File: rtl/spi_fsm_pkg.sv
// rtl/spi_fsm_pkg.sv - shared types and constants for the SPI slave transaction controller
//
// Purpose: state encoding of the transaction FSM, the read/write bit
// encoding carried in bit 0 of the address byte, and a helper that selects
// which conditioned SCLK edge a state counts.
//
// Contents:
//   stateT           transaction FSM states
//   RW_READ/RW_WRITE meaning of rw_bit
//   countedEdge()    edge pulse counted by a given state (0 if none)

package spi_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GET_ADDR   = 3'd1,
    GOT_ADDR   = 3'd2,
    READ_LOAD  = 3'd3,
    READ_SEND  = 3'd4,
    WRITE_GET  = 3'd5,
    WRITE_DATA = 3'd6,
    DONE       = 3'd7
  } stateT;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Address and write data are shifted in on SCLK rising edges; read data
  // is shifted out on falling edges. Any other state counts nothing, so a
  // stray pulse there cannot move the counter.
  function automatic logic countedEdge(stateT s, logic pe, logic ne);
    logic en;
    en = 1'b0;
    case (s)
      GET_ADDR,
      WRITE_GET: en = pe;
      READ_SEND: en = ne;
      default:   en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - SCLK edge counter for one SPI byte
//
// Purpose: counts qualified edge pulses within one FSM state and flags the
// pulse that completes a byte.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   clear    in   return count to zero (wins over countEn)
//   countEn  in   one qualified edge pulse this cycle
//   done     out  high in the same cycle as the width-th counted pulse

module spi_bit_counter #(
  parameter int width = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic countEn,
  output logic done
);

  localparam int cntW = $clog2(width + 1);
  localparam logic [cntW-1:0] lastCount = cntW'(width - 1);

  logic [cntW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (countEn) begin
      count <= count + cntW'(1);
    end
  end

  // Combinational so the FSM can leave its counting state on the very
  // cycle that carries the last pulse; the stored count never reaches width.
  assign done = countEn && (count == lastCount);

endmodule

// File: rtl/spi_fsm.sv
// rtl/spi_fsm.sv - SPI slave transaction controller
//
// Purpose: frames a chip-select transaction, counts conditioned SCLK edges,
// decodes read/write from the address byte and issues one-cycle strobes to
// the address latch, data memory and shift register parallel load. Enables
// the MISO buffer while read data is shifted out.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   cs            in   conditioned chip select, active low
//   sclk_pe       in   one-clk pulse per conditioned SCLK rising edge
//   sclk_ne       in   one-clk pulse per conditioned SCLK falling edge
//   rw_bit        in   shift register bit 0 (1 = read, 0 = write)
//   addr_we       out  address latch write strobe
//   dm_we         out  data memory write strobe
//   sr_we         out  shift register parallel load
//   miso_buff_en  out  MISO tri-state buffer enable

module spi_fsm
  import spi_fsm_pkg::*;
#(
  parameter int width = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cs,
  input  logic sclk_pe,
  input  logic sclk_ne,
  input  logic rw_bit,
  output logic addr_we,
  output logic dm_we,
  output logic sr_we,
  output logic miso_buff_en
);

  stateT state;
  stateT nextState;

  logic countEn;
  logic cntClear;
  logic cntDone;

  assign countEn = countedEdge(state, sclk_pe, sclk_ne);

  // Every state change restarts the count, which also covers the cs abort
  // path back to IDLE.
  assign cntClear = (nextState != state);

  spi_bit_counter #(
    .width (width)
  ) bitCounter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cntClear),
    .countEn (countEn),
    .done    (cntDone)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; a high cs overrides any edge pulse in the same cycle.
  always_comb begin
    nextState = state;
    if (cs) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:       nextState = GET_ADDR;
        GET_ADDR:   if (cntDone) nextState = GOT_ADDR;
        GOT_ADDR: begin
          case (rw_bit)
            RW_READ:  nextState = READ_LOAD;
            RW_WRITE: nextState = WRITE_GET;
            default:  nextState = WRITE_GET;
          endcase
        end
        READ_LOAD:  nextState = READ_SEND;
        READ_SEND:  if (cntDone) nextState = DONE;
        WRITE_GET:  if (cntDone) nextState = WRITE_DATA;
        WRITE_DATA: nextState = DONE;
        DONE:       nextState = DONE;
        default:    nextState = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    addr_we      = 1'b0;
    dm_we        = 1'b0;
    sr_we        = 1'b0;
    miso_buff_en = 1'b0;
    case (state)
      GOT_ADDR:   addr_we      = 1'b1;
      READ_LOAD:  sr_we        = 1'b1;
      READ_SEND:  miso_buff_en = 1'b1;
      WRITE_DATA: dm_we        = 1'b1;
      default: begin
        addr_we      = 1'b0;
        dm_we        = 1'b0;
        sr_we        = 1'b0;
        miso_buff_en = 1'b0;
      end
    endcase
  end

endmodule
